// File: rtl/Types.sv
// Shared pipeline types: datapath word, FU completion bundle and ROB entry/retire records.
package Types;
  localparam int ROB_IDX_W = 4;
  localparam int ROB_NUM_W = 6;

  typedef logic [31:0] word;

  typedef struct packed {
    logic                 ready;
    logic [ROB_NUM_W-1:0] ROBNumber;
    word                  FU_Result;
  } complete_stage_struct;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] rd;
    logic       regwrite;
    logic       memwrite;
    word        value;
  } rob_entry_struct;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memwrite;
    word        value;
  } retire_struct;
endpackage

// File: rtl/rob_retire_select.sv
// In-order retire picker: head retires when finished, head+1 only behind it.
module rob_retire_select (
  input  logic       i_head_busy,
  input  logic       i_head_done,
  input  logic       i_next_busy,
  input  logic       i_next_done,
  output logic [1:0] o_en,
  output logic [1:0] o_cnt
);
  always_comb begin
    o_en    = '0;
    o_en[0] = i_head_busy && i_head_done;
    o_en[1] = o_en[0] && i_next_busy && i_next_done;
    o_cnt   = {1'b0, o_en[0]} + {1'b0, o_en[1]};
  end
endmodule

// File: rtl/complete_rob.sv
// Reorder buffer / completion stage: alloc, 3-slot complete, wakeup, 2-wide retire.
// Optional flush port enabled by COMPLETE_ROB_FLUSH_EN.
module complete_rob
  import Types::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int RETIRE_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
`ifdef COMPLETE_ROB_FLUSH_EN
  input  logic                 i_flush,
`endif
  input  logic                 i_alloc_valid,
  input  logic [4:0]           i_alloc_rd,
  input  logic                 i_alloc_regwrite,
  input  logic                 i_alloc_memwrite,
  output logic                 o_alloc_ready,
  output logic [ROB_IDX_W-1:0] o_alloc_rob,
  input  complete_stage_struct i_complete_result [3],
  output logic                 o_wakeup_valid [3],
  output logic [ROB_IDX_W-1:0] o_wakeup_rob [3],
  output word                  o_wakeup_value [3],
  output logic                 o_retire_valid [RETIRE_W],
  output logic [4:0]           o_retire_rd [RETIRE_W],
  output logic                 o_retire_regwrite [RETIRE_W],
  output logic                 o_retire_memwrite [RETIRE_W],
  output word                  o_retire_value [RETIRE_W],
  output logic [ROB_IDX_W:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty
);
  localparam logic [ROB_IDX_W-1:0] IDX_MASK = ROB_IDX_W'(ROB_DEPTH - 1);
  localparam logic [ROB_IDX_W:0]   DEPTH_C  = (ROB_IDX_W + 1)'(ROB_DEPTH);

  rob_entry_struct        rob_q [ROB_DEPTH];
  rob_entry_struct        rob_d [ROB_DEPTH];
  logic [ROB_IDX_W-1:0]   head_q, head_d, tail_q, tail_d, head_nxt;
  logic [ROB_IDX_W:0]     count_q, count_d;
  logic                   wk_valid_q [3];
  logic                   wk_valid_d [3];
  logic [ROB_IDX_W-1:0]   wk_rob_q [3];
  logic [ROB_IDX_W-1:0]   wk_rob_d [3];
  word                    wk_value_q [3];
  word                    wk_value_d [3];
  retire_struct           ret_q [2];
  retire_struct           ret_d [2];
  logic [ROB_IDX_W-1:0]   cidx [3];
  logic                   acc [3];
  logic [ROB_IDX_W-1:0]   ret_ptr [2];
  logic [1:0]             ret_en;
  logic [1:0]             ret_cnt;
  logic                   alloc_fire;

  assign head_nxt   = (head_q + 1'b1) & IDX_MASK;
  assign ret_ptr[0] = head_q;
  assign ret_ptr[1] = head_nxt;

  rob_retire_select u_sel (
    .i_head_busy (rob_q[head_q].busy),
    .i_head_done (rob_q[head_q].done),
    .i_next_busy (rob_q[head_nxt].busy),
    .i_next_done (rob_q[head_nxt].done),
    .o_en        (ret_en),
    .o_cnt       (ret_cnt)
  );

  assign o_full        = (count_q == DEPTH_C);
  assign o_empty       = (count_q == '0);
  assign o_alloc_ready = !o_full;
  assign o_alloc_rob   = tail_q;
  assign o_count       = count_q;
  assign alloc_fire    = i_alloc_valid && o_alloc_ready;

  always_comb begin
    rob_d   = rob_q;
    head_d  = (head_q + ROB_IDX_W'(ret_cnt)) & IDX_MASK;
    tail_d  = (tail_q + ROB_IDX_W'(alloc_fire)) & IDX_MASK;
    count_d = count_q + (ROB_IDX_W + 1)'(alloc_fire)
            - (ROB_IDX_W + 1)'(ret_cnt);
    // Acceptance sees pre-edge state; later slots overwrite earlier ones.
    for (int s = 0; s < 3; s++) begin
      cidx[s] = i_complete_result[s].ROBNumber[ROB_IDX_W-1:0];
      acc[s]  = (i_complete_result[s].ready === 1'b1)
             && (int'(i_complete_result[s].ROBNumber) < ROB_DEPTH)
             && rob_q[cidx[s]].busy && !rob_q[cidx[s]].done;
      wk_valid_d[s] = acc[s];
      wk_rob_d[s]   = acc[s] ? cidx[s] : '0;
      wk_value_d[s] = acc[s] ? i_complete_result[s].FU_Result : '0;
    end
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) begin
        rob_d[cidx[s]].done  = 1'b1;
        rob_d[cidx[s]].value = i_complete_result[s].FU_Result;
      end
    end
    for (int k = 0; k < 2; k++) begin
      ret_d[k] = '0;
      if (ret_en[k]) begin
        ret_d[k] = '{valid:    1'b1,
                     rd:       rob_q[ret_ptr[k]].rd,
                     regwrite: rob_q[ret_ptr[k]].regwrite,
                     memwrite: rob_q[ret_ptr[k]].memwrite,
                     value:    rob_q[ret_ptr[k]].value};
        rob_d[ret_ptr[k]] = '0;
      end
    end
    if (alloc_fire) begin
      rob_d[tail_q] = '{busy:     1'b1,
                        done:     1'b0,
                        rd:       i_alloc_rd,
                        regwrite: i_alloc_regwrite,
                        memwrite: i_alloc_memwrite,
                        value:    '0};
    end
`ifdef COMPLETE_ROB_FLUSH_EN
    if (i_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_d[i] = '0;
      head_d  = head_q;
      tail_d  = head_q;
      count_d = '0;
      for (int s = 0; s < 3; s++) begin
        wk_valid_d[s] = 1'b0;
        wk_rob_d[s]   = '0;
        wk_value_d[s] = '0;
      end
      ret_d[0] = '0;
      ret_d[1] = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int s = 0; s < 3; s++) begin
        wk_valid_q[s] <= 1'b0;
        wk_rob_q[s]   <= '0;
        wk_value_q[s] <= '0;
      end
      ret_q[0] <= '0;
      ret_q[1] <= '0;
    end else begin
      rob_q      <= rob_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wk_valid_q <= wk_valid_d;
      wk_rob_q   <= wk_rob_d;
      wk_value_q <= wk_value_d;
      ret_q      <= ret_d;
    end
  end

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      o_wakeup_valid[s] = wk_valid_q[s];
      o_wakeup_rob[s]   = wk_rob_q[s];
      o_wakeup_value[s] = wk_value_q[s];
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      o_retire_valid[k]    = ret_q[k].valid;
      o_retire_rd[k]       = ret_q[k].rd;
      o_retire_regwrite[k] = ret_q[k].regwrite;
      o_retire_memwrite[k] = ret_q[k].memwrite;
      o_retire_value[k]    = ret_q[k].value;
    end
  end
endmodule

// File: tb/tb_complete_rob.sv
// Scoreboard bench for complete_rob: program-order queue model predicts
// wakeups, retires and occupancy; a monitor pops and compares each cycle.
module tb_complete_rob;
  import Types::*;

  localparam int D = 16;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        done;
    logic [31:0] val;
  } ment_t;

  typedef struct {
    int          cyc;
    int          slot;
    int          rob;
    logic [31:0] val;
  } wk_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [31:0] val;
  } rt_t;

  typedef struct {
    int cyc;
    int cnt;
  } ct_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 alloc_valid;
  logic [4:0]           alloc_rd;
  logic                 alloc_rw;
  logic                 alloc_mw;
  logic                 alloc_ready;
  logic [ROB_IDX_W-1:0] alloc_rob;
  complete_stage_struct comp [3];
  logic                 wk_valid [3];
  logic [ROB_IDX_W-1:0] wk_rob [3];
  word                  wk_value [3];
  logic                 rt_valid [2];
  logic [4:0]           rt_rd [2];
  logic                 rt_rw [2];
  logic                 rt_mw [2];
  word                  rt_value [2];
  logic [ROB_IDX_W:0]   count;
  logic                 full;
  logic                 empty;

  int    n_vec = 0;
  int    n_err = 0;
  int    edge_n = 0;
  bit    mon_en = 0;
  ment_t mq[$];
  int    mhead = 0;
  wk_t   wq[$];
  rt_t   rq[$];
  ct_t   cq[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  complete_rob #(.ROB_DEPTH(D), .RETIRE_W(2)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
`ifdef COMPLETE_ROB_FLUSH_EN
    .i_flush           (flush),
`endif
    .i_alloc_valid     (alloc_valid),
    .i_alloc_rd        (alloc_rd),
    .i_alloc_regwrite  (alloc_rw),
    .i_alloc_memwrite  (alloc_mw),
    .o_alloc_ready     (alloc_ready),
    .o_alloc_rob       (alloc_rob),
    .i_complete_result (comp),
    .o_wakeup_valid    (wk_valid),
    .o_wakeup_rob      (wk_rob),
    .o_wakeup_value    (wk_value),
    .o_retire_valid    (rt_valid),
    .o_retire_rd       (rt_rd),
    .o_retire_regwrite (rt_rw),
    .o_retire_memwrite (rt_mw),
    .o_retire_value    (rt_value),
    .o_count           (count),
    .o_full            (full),
    .o_empty           (empty)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: advance one clock edge from the driven inputs.
  task automatic step();
    int    k;
    int    sz;
    int    nret;
    bit    acc [3];
    int    pos [3];
    ment_t e;
    k = edge_n + 1;
    if (rst) begin
      mq.delete();
      mhead = 0;
      cq.push_back('{cyc: k, cnt: 0});
      return;
    end
    sz = mq.size();
    if (alloc_valid)
      chk("alloc_rob", 64'(alloc_rob), 64'((mhead + sz) % D));
    nret = 0;
    if (sz > 0 && mq[0].done) nret = 1;
    if (nret == 1 && sz > 1 && mq[1].done) nret = 2;
    for (int s = 0; s < 3; s++) begin
      acc[s] = 0;
      pos[s] = 0;
      if (comp[s].ready === 1'b1 && int'(comp[s].ROBNumber) < D) begin
        pos[s] = (int'(comp[s].ROBNumber) - mhead + D) % D;
        acc[s] = (pos[s] < sz) && !mq[pos[s]].done;
      end
    end
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) begin
        mq[pos[s]].done = 1'b1;
        mq[pos[s]].val  = comp[s].FU_Result;
        wq.push_back('{cyc: k, slot: s, rob: int'(comp[s].ROBNumber),
                       val: comp[s].FU_Result});
      end
    end
    for (int r = 0; r < nret; r++) begin
      e = mq.pop_front();
      rq.push_back('{cyc: k, rd: e.rd, rw: e.rw, mw: e.mw, val: e.val});
      mhead = (mhead + 1) % D;
    end
    if (alloc_valid && sz < D)
      mq.push_back('{rd: alloc_rd, rw: alloc_rw, mw: alloc_mw,
                     done: 1'b0, val: 32'h0});
    cq.push_back('{cyc: k, cnt: mq.size()});
  endtask

  task automatic idle_inputs();
    rst         = 1'b0;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_rw    = 1'b0;
    alloc_mw    = 1'b0;
    for (int s = 0; s < 3; s++) comp[s] = '0;
  endtask

  task automatic tick();
    step();
    mon_en = 1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic alloc(input int rd);
    alloc_valid = 1'b1;
    alloc_rd    = 5'(rd);
    alloc_rw    = 1'(rd);
    alloc_mw    = (rd % 3) == 0;
  endtask

  task automatic cmp(input int s, input int idx, input logic [31:0] v);
    comp[s] = '{ready: 1'b1, ROBNumber: 6'(idx), FU_Result: v};
  endtask

  // Monitor: compare whatever the DUT presents against queued expectations.
  initial begin
    wk_t wexp;
    rt_t rexp;
    ct_t cexp;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (cq.size() > 0) begin
          cexp = cq.pop_front();
          chk("count_cycle", 64'(edge_n), 64'(cexp.cyc));
          chk("count", 64'(count), 64'(cexp.cnt));
          chk("flags", {61'b0, full, empty, alloc_ready},
              {61'b0, cexp.cnt == D, cexp.cnt == 0, cexp.cnt != D});
        end
        for (int s = 0; s < 3; s++) begin
          if (wk_valid[s]) begin
            if (wq.size() == 0) begin
              chk($sformatf("wakeup%0d_unexpected", s), 64'(wk_rob[s]),
                  64'hFFFF);
            end else begin
              wexp = wq.pop_front();
              chk($sformatf("wakeup%0d_cycle", s), 64'(edge_n),
                  64'(wexp.cyc));
              chk($sformatf("wakeup%0d_data", s),
                  {20'b0, 8'(s), 4'(wk_rob[s]), wk_value[s]},
                  {20'b0, 8'(wexp.slot), 4'(wexp.rob), wexp.val});
            end
          end
        end
        for (int r = 0; r < 2; r++) begin
          if (rt_valid[r]) begin
            if (rq.size() == 0) begin
              chk($sformatf("retire%0d_unexpected", r), 64'(rt_rd[r]),
                  64'hFFFF);
            end else begin
              rexp = rq.pop_front();
              chk($sformatf("retire%0d_cycle", r), 64'(edge_n),
                  64'(rexp.cyc));
              chk($sformatf("retire%0d_data", r),
                  {25'b0, rt_rd[r], rt_rw[r], rt_mw[r], rt_value[r]},
                  {25'b0, rexp.rd, rexp.rw, rexp.mw, rexp.val});
            end
          end
        end
      end
    end
  end

  initial begin
    int sz;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("reset_wk_valid", {61'b0, wk_valid[0], wk_valid[1], wk_valid[2]}, 0);
    chk("reset_rt_valid", {62'b0, rt_valid[0], rt_valid[1]}, 0);
    chk("reset_values", {rt_value[0] | rt_value[1], wk_value[0] | wk_value[2]},
        0);

    // in-order retire of out-of-order completions
    for (int i = 1; i <= 3; i++) begin
      alloc(i);
      tick();
    end
    cmp(0, 2, 32'h30); tick();
    cmp(0, 0, 32'h10); tick();
    cmp(0, 1, 32'h20); tick();
    idle(3);

    // fill to full, then alloc attempt alongside a head retire
    rst = 1'b1; tick();
    for (int i = 0; i < D; i++) begin
      alloc(i + 4);
      tick();
    end
    alloc(9); tick();
    cmp(1, 0, 32'h1234); tick();
    alloc(10); tick();
    idle(1);

    // same-entry collision, slot 2 wins; X ready ignored
    cmp(0, 5, 32'hAA);
    cmp(2, 5, 32'hBB);
    comp[1] = '{ready: 1'bx, ROBNumber: 6'd6, FU_Result: 32'hCC};
    tick();
    for (int i = 1; i <= 4; i++) begin
      cmp(i % 3, i, 32'h100 + 32'(i));
      tick();
    end
    idle(4);

    // pointer wrap
    rst = 1'b1; tick();
    for (int i = 0; i < 14; i++) begin
      alloc(i);
      tick();
    end
    for (int i = 0; i < 14; i += 3) begin
      for (int s = 0; s < 3; s++)
        if (i + s < 14) cmp(s, i + s, 32'h200 + 32'(i + s));
      tick();
    end
    idle(10);
    for (int i = 0; i < 4; i++) begin
      alloc(20 + i);
      tick();
    end
    cmp(0, 15, 32'hF15); tick();
    cmp(1, 14, 32'hF14); tick();
    idle(3);

    // reset while head is about to retire
    rst = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      alloc(i + 1);
      tick();
    end
    cmp(0, 0, 32'h55); tick();
    rst = 1'b1; tick();
    idle(2);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(199) == 0) rst = 1'b1;
      if ($urandom_range(9) < 7) alloc(int'($urandom_range(31)));
      sz = mq.size();
      for (int s = 0; s < 3; s++) begin
        comp[s].ready     = ($urandom_range(9) < 8);
        comp[s].FU_Result = $urandom;
        if (sz > 0 && $urandom_range(3) != 0)
          comp[s].ROBNumber =
            6'((mhead + int'($urandom_range(sz - 1))) % D);
        else
          comp[s].ROBNumber = 6'($urandom_range(63));
      end
      tick();
    end
    idle(6);

    @(posedge clk);
    #2;
    chk("wakeup_pending", 64'(wq.size()), 0);
    chk("retire_pending", 64'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
